simple_axi_arbiter: RTL and testbench
=====================================

# simple_axi_arbiter

Shares one `simple_axi_master` internal-bus port among `NUM_REQ` requesters. It arbitrates pending requests, issues the winner's read or write to the master, and waits for completion. It then returns read data and status to the winning requester and clears the master's done flag. It sits between the core-side requesters and the master's `i_addr`/`i_wdata`/`i_rw` port.

## Interface
- `NUM_REQ`, 4, number of requesters (2..16)
- `DATA_WIDTH`, 32, data width; matches the master
- `ADDR_WIDTH`, 32, address width; matches the master
- `i_clk` in 1: clock
- `i_rst_n` in 1: reset, asynchronous assert, active-low
- `i_req` in NUM_REQ: per-requester request level
- `i_req_rw` in 2*NUM_REQ: per-requester op (00 nop, 01 write, 10 read, 11 reserved), slice k = [2k+1:2k]
- `i_req_addr` in ADDR_WIDTH*NUM_REQ: per-requester address
- `i_req_wdata` in DATA_WIDTH*NUM_REQ: per-requester write data
- `o_req_gnt` out NUM_REQ: one-hot, one-cycle grant pulse
- `o_resp_valid` out NUM_REQ: one-hot, one-cycle completion pulse
- `o_resp_rdata` out DATA_WIDTH: read data; valid with `o_resp_valid`
- `o_resp_error` out 1: AXI error or reserved op; valid with `o_resp_valid`
- `o_resp_invalid` out 1: DECERR; valid with `o_resp_valid`
- `o_busy` out 1: state != IDLE
- `m_addr` out ADDR_WIDTH, `m_wdata` out DATA_WIDTH, `m_rw` out 2, `m_clear_done` out 1: to the master
- `m_wait`, `m_done`, `m_error`, `m_invalid` in 1 each; `m_rdata` in DATA_WIDTH: from the master

## Operation
- States: IDLE, ISSUE, BUSY, RESP.
- **IDLE:** if any `i_req` is set, pick the winner `g` by round-robin, register `g`, and go to ISSUE. Otherwise stay in IDLE.
- **ISSUE** (1 cycle):
  - `o_req_gnt[g]=1`.
  - `m_addr`/`m_wdata` = slice `g`.
  - `m_rw` = `i_req_rw[g]` if 01/10, else 00.
  - Next state: BUSY for 01/10; RESP for 00/11, with error=1, invalid=0, rdata=0, and no master activity.
- **BUSY:**
  - `m_rw=00`.
  - When `m_done=1` and `m_wait=0`: capture `m_rdata` (reads only; writes return 0), `m_error` and `m_invalid`, then go to RESP.
  - `m_error`/`m_invalid` are only valid on that completion cycle, so they must be captured in the same cycle.
- **RESP** (1 cycle):
  - `o_resp_valid[g]=1` with the captured data.
  - `m_clear_done=1` only if a master op was issued.
  - Update the round-robin pointer to `g`, then go to IDLE.
- Requester rules:
  - Hold `i_req`, `i_req_rw`, `i_req_addr` and `i_req_wdata` stable until the `o_req_gnt` cycle.
  - Drop `i_req` by the cycle after the grant, unless it is issuing a new request.
  - A requester may re-raise `i_req` after `o_resp_valid`.
- `m_addr`/`m_wdata` are don't-care outside ISSUE; hold the slice of registered `g` to limit toggling.

## Timing
- Reset values:
  - state IDLE; all outputs 0.
  - `g`=0; round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
- Arbitration-to-grant latency is 1 cycle: request seen in IDLE at cycle t, `o_req_gnt` at t+1.
- `o_resp_valid` follows the master completion cycle by exactly 1 cycle.
- With a zero-wait slave, the master completes write and read in the same number of cycles; the completion pulse falls on the master's done cycle + 1.
- Reserved/nop op: ISSUE at t+1, RESP at t+2.
- Back-to-back: the earliest next arbitration is the IDLE cycle after RESP. A request raised during RESP is seen then.
- Simultaneous requests are resolved in one cycle. Losers wait and are not dropped.
- Round-robin order: search starts at pointer+1, wrapping modulo NUM_REQ.
- Async reset mid-transaction:
  - The arbiter returns to IDLE immediately and no `o_resp_valid` is emitted.
  - The master must be reset in the same event; the system reset ties both.
- `m_done` seen in IDLE/ISSUE (stale) is ignored.

## Configuration
- `SIMPLE_AXI_ARB_PRIORITY_EN` defined: fixed priority, lowest index wins, pointer unused. This can starve high indices and is documented as intended.
- Undefined (default): round-robin as above.

## Structure
- Package `simple_axi_pkg` holds:
  - `RW_NOP`/`RW_WRITE`/`RW_READ`/`RW_RSVD`
  - `RESP_OKAY`/`RESP_EXOKAY`/`RESP_SLVERR`/`RESP_DECERR`
  - the arbiter state typedef
- Sub-module `simple_axi_rr_pick` is combinational: inputs request vector and pointer; outputs winner index and valid. The macro selects the fixed-priority path inside it.
- The top holds the FSM, capture registers and muxes.

## Test plan
- Single read: req0 rw=10 addr 0x1000; slave returns 0xDEADBEEF OKAY → `o_resp_valid[0]`, rdata 0xDEADBEEF, error 0, `m_clear_done` pulses in the same cycle.
- Simultaneous write: req1 and req3 write at the same cycle after reset → grant order 1 then 3 (round-robin). With `SIMPLE_AXI_ARB_PRIORITY_EN` the order is still 1 then 3. Then all four requesters held high → round-robin grants 0,1,2,3,0.
- DECERR read at 0xFFFF0000 → error 1, invalid 1, rdata captured. SLVERR write → error 1, invalid 0.
- Reserved op: req2 rw=11 → gnt at t+1, resp at t+2 with error 1, `m_rw` never nonzero, `m_clear_done` 0.
- Reset mid-op: deassert `i_rst_n` during BUSY (slave stalling AWREADY) → all outputs 0 immediately. After release, a new req0 read completes normally.
- Starvation check: req0 re-requests right after every response while req2 is pending → req2 is granted within 2 transactions (round-robin build).

Source files
------------

// File: rtl/simple_axi_pkg.sv
// Shared constants and state type for the simple_axi arbiter slice.
// Holds op codes, AXI response codes and the arbiter FSM state enum.
package simple_axi_pkg;

   localparam logic [1:0] RW_NOP   = 2'b00;
   localparam logic [1:0] RW_WRITE = 2'b01;
   localparam logic [1:0] RW_READ  = 2'b10;
   localparam logic [1:0] RW_RSVD  = 2'b11;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      BUSY,
      RESP
   } arb_state_t;

endpackage

// File: rtl/simple_axi_rr_pick.sv
// Combinational winner picker: round-robin from ptr+1, or fixed
// priority (lowest index) when SIMPLE_AXI_ARB_PRIORITY_EN is defined.
// Ports: req (request vector), ptr (last winner) -> idx, valid.
module simple_axi_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   idx,
   output logic               valid
);

`ifdef SIMPLE_AXI_ARB_PRIORITY_EN
   logic unused_ptr;
   assign unused_ptr = ^ptr;

   // Scan high to low so the lowest set index is written last.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx   = IDX_W'(i);
            valid = 1'b1;
         end
      end
   end
`else
   logic [IDX_W-1:0] k;

   // Scan farthest to nearest so ptr+1 is written last.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      k     = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         k = IDX_W'((int'(ptr) + i) % NUM_REQ);
         if (req[k]) begin
            idx   = k;
            valid = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/simple_axi_arbiter.sv
// Shares one simple_axi_master port among NUM_REQ requesters.
// Ports: i_req*/o_req_gnt/o_resp_* to requesters, m_* to the master.
// Build option: SIMPLE_AXI_ARB_PRIORITY_EN selects fixed priority.
module simple_axi_arbiter
   import simple_axi_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic [NUM_REQ-1:0]             i_req,
   input  logic [2*NUM_REQ-1:0]           i_req_rw,
   input  logic [ADDR_WIDTH*NUM_REQ-1:0]  i_req_addr,
   input  logic [DATA_WIDTH*NUM_REQ-1:0]  i_req_wdata,
   output logic [NUM_REQ-1:0]             o_req_gnt,
   output logic [NUM_REQ-1:0]             o_resp_valid,
   output logic [DATA_WIDTH-1:0]          o_resp_rdata,
   output logic                           o_resp_error,
   output logic                           o_resp_invalid,
   output logic                           o_busy,
   output logic [ADDR_WIDTH-1:0]          m_addr,
   output logic [DATA_WIDTH-1:0]          m_wdata,
   output logic [1:0]                     m_rw,
   output logic                           m_clear_done,
   input  logic                           m_wait,
   input  logic                           m_done,
   input  logic                           m_error,
   input  logic                           m_invalid,
   input  logic [DATA_WIDTH-1:0]          m_rdata
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [1:0]            rw_a    [NUM_REQ];
   logic [ADDR_WIDTH-1:0] addr_a  [NUM_REQ];
   logic [DATA_WIDTH-1:0] wdata_a [NUM_REQ];

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
      assign rw_a[k]    = i_req_rw[2*k +: 2];
      assign addr_a[k]  = i_req_addr[ADDR_WIDTH*k +: ADDR_WIDTH];
      assign wdata_a[k] = i_req_wdata[DATA_WIDTH*k +: DATA_WIDTH];
   end

   arb_state_t            state, state_n;
   logic [IDX_W-1:0]      g, ptr, win;
   logic                  win_v;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
   logic                  err_q, inv_q, issued_q, rd_q;
   logic [1:0]            rw_g;
   logic                  op_ok, cmpl;
   logic [NUM_REQ-1:0]    onehot_g;

   simple_axi_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req   (i_req),
      .ptr   (ptr),
      .idx   (win),
      .valid (win_v)
   );

   assign rw_g     = rw_a[g];
   assign op_ok    = (rw_g == RW_WRITE) || (rw_g == RW_READ);
   assign cmpl     = m_done && !m_wait;
   assign onehot_g = NUM_REQ'(1) << g;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:  if (win_v) state_n = ISSUE;
         ISSUE: state_n = op_ok ? BUSY : RESP;
         BUSY:  if (cmpl) state_n = RESP;
         RESP:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Address/data are latched at arbitration; requesters hold them
   // stable through the grant, so this equals slice g during ISSUE.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         g        <= '0;
         ptr      <= IDX_W'(NUM_REQ - 1);
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         inv_q    <= 1'b0;
         issued_q <= 1'b0;
         rd_q     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (win_v) begin
                  g       <= win;
                  addr_q  <= addr_a[win];
                  wdata_q <= wdata_a[win];
               end
            end
            ISSUE: begin
               issued_q <= op_ok;
               rd_q     <= (rw_g == RW_READ);
               if (!op_ok) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
                  inv_q   <= 1'b0;
               end
            end
            // Master error flags are only valid on the done cycle.
            BUSY: begin
               if (cmpl) begin
                  rdata_q <= rd_q ? m_rdata : '0;
                  err_q   <= m_error;
                  inv_q   <= m_invalid;
               end
            end
            RESP: ptr <= g;
            default: ;
         endcase
      end
   end

   assign o_req_gnt      = (state == ISSUE) ? onehot_g : '0;
   assign o_resp_valid   = (state == RESP) ? onehot_g : '0;
   assign o_resp_rdata   = rdata_q;
   assign o_resp_error   = err_q;
   assign o_resp_invalid = inv_q;
   assign o_busy         = (state != IDLE);
   assign m_addr         = addr_q;
   assign m_wdata        = wdata_q;
   assign m_rw           = (state == ISSUE && op_ok) ? rw_g : RW_NOP;
   assign m_clear_done   = (state == RESP) && issued_q;

endmodule

// File: tb/tb_simple_axi_arbiter.sv
// Self-checking bench for simple_axi_arbiter with a master model.
// Grants and responses are checked against queued expectations.
module tb_simple_axi_arbiter;
   import simple_axi_pkg::*;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int AW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic [N-1:0]  req;
   logic [1:0]    op_a [N];
   logic [AW-1:0] ad_a [N];
   logic [DW-1:0] wd_a [N];
   logic [2*N-1:0]  req_rw;
   logic [AW*N-1:0] req_addr;
   logic [DW*N-1:0] req_wdata;
   logic [N-1:0]  gnt, resp_valid;
   logic [DW-1:0] resp_rdata;
   logic          resp_error, resp_invalid, busy;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_rdata;
   logic [1:0]    m_rw;
   logic          m_clear_done, m_wait, m_done, m_error, m_invalid;

   always_comb begin
      req_rw    = '0;
      req_addr  = '0;
      req_wdata = '0;
      for (int k = 0; k < N; k++) begin
         req_rw[2*k +: 2]     = op_a[k];
         req_addr[AW*k +: AW]  = ad_a[k];
         req_wdata[DW*k +: DW] = wd_a[k];
      end
   end

   simple_axi_arbiter #(
      .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
   ) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_req          (req),
      .i_req_rw       (req_rw),
      .i_req_addr     (req_addr),
      .i_req_wdata    (req_wdata),
      .o_req_gnt      (gnt),
      .o_resp_valid   (resp_valid),
      .o_resp_rdata   (resp_rdata),
      .o_resp_error   (resp_error),
      .o_resp_invalid (resp_invalid),
      .o_busy         (busy),
      .m_addr         (m_addr),
      .m_wdata        (m_wdata),
      .m_rw           (m_rw),
      .m_clear_done   (m_clear_done),
      .m_wait         (m_wait),
      .m_done         (m_done),
      .m_error        (m_error),
      .m_invalid      (m_invalid),
      .m_rdata        (m_rdata)
   );

   function automatic logic [1:0] slave_code(logic [AW-1:0] a);
      if (a == 32'hFFFF_0000)      return RESP_DECERR;
      else if (a == 32'hEEEE_0000) return RESP_SLVERR;
      else if (a == 32'h0000_3000) return RESP_EXOKAY;
      else                         return RESP_OKAY;
   endfunction

   function automatic logic [DW-1:0] slave_rdata(logic [AW-1:0] a);
      if (a == 32'hFFFF_0000)      return 32'hBAD0_BAD0;
      else if (a == 32'h0000_1000) return 32'hDEAD_BEEF;
      else                         return a ^ 32'hA5A5_A5A5;
   endfunction

   // Master model: sticky done until cleared, error flags for one cycle.
   bit            stall;
   logic          mact, mrd_q;
   logic [AW-1:0] ma_q;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_done <= 1'b0; m_wait <= 1'b0; m_error <= 1'b0;
         m_invalid <= 1'b0; m_rdata <= '0;
         mact <= 1'b0; mrd_q <= 1'b0; ma_q <= '0;
      end else begin
         m_error   <= 1'b0;
         m_invalid <= 1'b0;
         if (m_clear_done) m_done <= 1'b0;
         if (m_rw != RW_NOP) begin
            mact   <= 1'b1;
            m_wait <= 1'b1;
            ma_q   <= m_addr;
            mrd_q  <= (m_rw == RW_READ);
         end else if (mact && !stall) begin
            mact      <= 1'b0;
            m_wait    <= 1'b0;
            m_done    <= 1'b1;
            m_rdata   <= mrd_q ? slave_rdata(ma_q) : 32'h5555_AAAA;
            m_error   <= (slave_code(ma_q) == RESP_SLVERR) ||
                         (slave_code(ma_q) == RESP_DECERR);
            m_invalid <= (slave_code(ma_q) == RESP_DECERR);
         end
      end
   end

   typedef struct {
      int            idx;
      logic [DW-1:0] rdata;
      logic          err;
      logic          inv;
      logic          clr;
   } exp_t;

   exp_t rq[$];
   int   gq[$];
   int   n_chk = 0;
   int   n_pass = 0;
   int   mrw_cnt, clr_cnt;
   logic [N-1:0] hold, rereq;

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic expect_txn(int k, logic [1:0] op, logic [AW-1:0] a);
      exp_t e;
      logic [1:0] c;
      c = slave_code(a);
      e.idx = k;
      if (op == RW_WRITE || op == RW_READ) begin
         e.rdata = (op == RW_READ) ? slave_rdata(a) : '0;
         e.err   = (c == RESP_SLVERR) || (c == RESP_DECERR);
         e.inv   = (c == RESP_DECERR);
         e.clr   = 1'b1;
      end else begin
         e.rdata = '0;
         e.err   = 1'b1;
         e.inv   = 1'b0;
         e.clr   = 1'b0;
      end
      gq.push_back(k);
      rq.push_back(e);
   endtask

   task automatic drive(int k, logic [1:0] op, logic [AW-1:0] a,
                        logic [DW-1:0] wd);
      op_a[k] = op;
      ad_a[k] = a;
      wd_a[k] = wd;
      req[k]  = 1'b1;
   endtask

   task automatic monitor();
      int   k;
      exp_t e;
      logic [1:0] exp_rw;
      forever begin
         @(negedge clk);
         if (m_rw != RW_NOP) mrw_cnt++;
         if (m_clear_done)   clr_cnt++;
         if (gnt != '0) begin
            if (gq.size() == 0) chk("gnt_unexpected", 64'(gnt), 0);
            else begin
               k = gq.pop_front();
               exp_rw = (op_a[k] == RW_WRITE || op_a[k] == RW_READ)
                        ? op_a[k] : RW_NOP;
               chk("gnt_vec", 64'(gnt), 64'(1 << k));
               chk("gnt_addr", 64'(m_addr), 64'(ad_a[k]));
               chk("gnt_wdata", 64'(m_wdata), 64'(wd_a[k]));
               chk("gnt_rw", 64'(m_rw), 64'(exp_rw));
            end
            for (int j = 0; j < N; j++)
               if (gnt[j] && !hold[j]) req[j] = 1'b0;
         end
         if (resp_valid != '0) begin
            if (rq.size() == 0) chk("resp_unexpected", 64'(resp_valid), 0);
            else begin
               e = rq.pop_front();
               chk("resp_vec", 64'(resp_valid), 64'(1 << e.idx));
               chk("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
               chk("resp_err", 64'(resp_error), 64'(e.err));
               chk("resp_inv", 64'(resp_invalid), 64'(e.inv));
               chk("resp_clr", 64'(m_clear_done), 64'(e.clr));
            end
            for (int j = 0; j < N; j++)
               if (resp_valid[j] && rereq[j]) req[j] = 1'b1;
         end
      end
   endtask

   task automatic wait_done(string tag);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (gq.size() == 0 && rq.size() == 0 && !busy) break;
      end
      chk({tag, "_drain"}, 64'((gq.size() + rq.size()) * 2) + 64'(busy), 0);
   endtask

   task automatic wait_gq(string tag);
      for (int i = 0; i < 300 && gq.size() != 0; i++) @(negedge clk);
      chk({tag, "_grants"}, 64'(gq.size()), 0);
   endtask

   task automatic chk_quiet(string tag);
      chk({tag, "_busy"}, 64'(busy), 0);
      chk({tag, "_gnt"}, 64'(gnt), 0);
      chk({tag, "_rvalid"}, 64'(resp_valid), 0);
      chk({tag, "_mrw"}, 64'(m_rw), 0);
      chk({tag, "_mclr"}, 64'(m_clear_done), 0);
      chk({tag, "_maddr"}, 64'(m_addr), 0);
      chk({tag, "_rdata"}, 64'(resp_rdata), 0);
      chk({tag, "_err"}, 64'({resp_error, resp_invalid}), 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, k0, i;
      rst_n = 1'b0; req = '0; hold = '0; rereq = '0; stall = 1'b0;
      mrw_cnt = 0; clr_cnt = 0;
      for (int k = 0; k < N; k++) begin
         op_a[k] = RW_NOP; ad_a[k] = '0; wd_a[k] = '0;
      end
      fork monitor(); join_none
      repeat (2) @(negedge clk);
      chk_quiet("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Single read with exact latency checks.
      drive(0, RW_READ, 32'h0000_1000, '0);
      expect_txn(0, RW_READ, 32'h0000_1000);
      @(negedge clk);
      chk("t1_gnt_lat", 64'(gnt), 64'h1);
      @(negedge clk);
      @(negedge clk);
      chk("t1_early", 64'(resp_valid), 0);
      chk("t1_cmpl", 64'({m_done, m_wait}), 64'h2);
      @(negedge clk);
      chk("t1_resp_lat", 64'(resp_valid), 64'h1);
      chk("t1_clr", 64'(m_clear_done), 1);
      wait_done("t1");

      // Simultaneous writes from 1 and 3.
      drive(1, RW_WRITE, 32'h0000_2000, 32'h1111_1111);
      drive(3, RW_WRITE, 32'h0000_4000, 32'h3333_3333);
      expect_txn(1, RW_WRITE, 32'h0000_2000);
      expect_txn(3, RW_WRITE, 32'h0000_4000);
      wait_done("t2");

      // All four held high: rotation 0,1,2,3,0.
      hold = '1;
      for (int k = 0; k < N; k++)
         drive(k, RW_READ, 32'h0001_0000 + 32'(k * 256), '0);
      for (int k = 0; k < N; k++)
         expect_txn(k, RW_READ, 32'h0001_0000 + 32'(k * 256));
      expect_txn(0, RW_READ, 32'h0001_0000);
      wait_gq("t3");
      hold = '0;
      req  = '0;
      wait_done("t3");

      // DECERR read, SLVERR write.
      drive(1, RW_READ, 32'hFFFF_0000, '0);
      expect_txn(1, RW_READ, 32'hFFFF_0000);
      wait_done("t4a");
      drive(2, RW_WRITE, 32'hEEEE_0000, 32'h2222_2222);
      expect_txn(2, RW_WRITE, 32'hEEEE_0000);
      wait_done("t4b");

      // Reserved op: no master activity.
      c0 = mrw_cnt;
      k0 = clr_cnt;
      drive(2, RW_RSVD, 32'h0000_5000, 32'h5);
      expect_txn(2, RW_RSVD, 32'h0000_5000);
      @(negedge clk);
      chk("t5_gnt_lat", 64'(gnt), 64'h4);
      @(negedge clk);
      chk("t5_resp_lat", 64'(resp_valid), 64'h4);
      chk("t5_err", 64'(resp_error), 1);
      wait_done("t5");
      chk("t5_mrw_quiet", 64'(mrw_cnt - c0), 0);
      chk("t5_clr_quiet", 64'(clr_cnt - k0), 0);

      // Async reset while the slave stalls.
      stall = 1'b1;
      drive(0, RW_READ, 32'h0000_1000, '0);
      gq.push_back(0);
      repeat (3) @(negedge clk);
      chk("t6_busy", 64'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk_quiet("t6_rst");
      @(negedge clk);
      stall = 1'b0;
      req = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      drive(0, RW_READ, 32'h0000_1000, '0);
      expect_txn(0, RW_READ, 32'h0000_1000);
      wait_done("t6");

      // Starvation: 0 keeps re-requesting, 2 must still get in.
      rereq[0] = 1'b1;
      drive(0, RW_READ, 32'h0000_1000, '0);
      expect_txn(0, RW_READ, 32'h0000_1000);
      for (i = 0; i < 50 && !gnt[0]; i++) @(negedge clk);
      chk("t7_first_gnt", 64'(gnt[0]), 1);
      drive(2, RW_READ, 32'h0000_2200, '0);
      expect_txn(2, RW_READ, 32'h0000_2200);
      expect_txn(0, RW_READ, 32'h0000_1000);
      wait_gq("t7");
      rereq[0] = 1'b0;
      wait_done("t7");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
